// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI frame receiver.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        HOLD  = 2'b10
    } spi_state_t;

    localparam int SPI_DATA_W      = 12;
    localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync.sv
// N-flop single-bit synchronizer with a configurable reset value.
module spi_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] r_sync;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= {N{RST_VAL}};
        end else begin
            r_sync <= {r_sync[N-2:0], d};
        end
    end

    assign q = r_sync[N-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: LSB-first DATA_W-bit frames with valid/ready output.
// Define SPI_RX_FRAME_ERR_EN to add the frame_err abort pulse output.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              overrun
`ifdef SPI_RX_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int FL_W  = $clog2(SYNC_STAGES + 1);

    logic w_sclk_sync;
    logic w_cs_sync;
    logic w_mosi_sync;
    logic w_sample;
    logic w_cs_fall;

    logic              r_sclk_prev;
    logic              r_cs_prev;
    logic [FL_W-1:0]   r_flush;
    spi_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_done;
    logic [DATA_W-1:0] r_dout;
    logic              r_valid;
    logic              r_overrun;
`ifdef SPI_RX_FRAME_ERR_EN
    logic              r_frame_err;
`endif

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(w_sclk_sync)
    );
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(cs), .q(w_cs_sync)
    );
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi), .q(w_mosi_sync)
    );

    assign w_sample  = w_sclk_sync & ~r_sclk_prev & ~w_cs_sync;
    assign w_cs_fall = r_cs_prev & ~w_cs_sync;

    // Edge-detect history; the cs history is held low until the reset value
    // of the cs synchronizer has drained, so a frame already in flight at
    // reset release never looks like a fresh cs fall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
            r_flush     <= FL_W'(SYNC_STAGES);
        end else begin
            r_sclk_prev <= w_sclk_sync;
            if (r_flush != {FL_W{1'b0}}) begin
                r_flush   <= r_flush - FL_W'(1);
                r_cs_prev <= 1'b0;
            end else begin
                r_cs_prev <= w_cs_sync;
            end
        end
    end

    // Frame FSM with bit counter and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_shift <= {DATA_W{1'b0}};
            r_done  <= 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
            r_frame_err <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
            r_frame_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state <= SHIFT;
                        r_cnt   <= {CNT_W{1'b0}};
                    end
                end
                SHIFT: begin
                    if (w_cs_sync) begin
                        r_state <= IDLE;
`ifdef SPI_RX_FRAME_ERR_EN
                        r_frame_err <= 1'b1;
`endif
                    end else if (w_sample) begin
                        r_shift <= {w_mosi_sync, r_shift[DATA_W-1:1]};
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(DATA_W - 1)) begin
                            r_state <= HOLD;
                            r_done  <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_cs_sync) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Output holding register: load, handshake and sticky overrun.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dout    <= {DATA_W{1'b0}};
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_done) begin
                if (!r_valid || dout_ready) begin
                    r_dout  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && dout_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign overrun    = r_overrun;
`ifdef SPI_RX_FRAME_ERR_EN
    assign frame_err  = r_frame_err;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed, table-driven bench for spi_slave_rx (12-bit frames, 2-stage sync).
module tb_spi_slave_rx;

    localparam int DW   = 12;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          sclk;
    logic          cs;
    logic          mosi;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          overrun;
`ifdef SPI_RX_FRAME_ERR_EN
    logic          frame_err;
`endif

    spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun)
`ifdef SPI_RX_FRAME_ERR_EN
        ,
        .frame_err  (frame_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          nedges;
        logic [11:0] exp_dout;
        int          exp_valids;
        int          exp_ferr;
        bit          chk_lat;
    } vec_t;

    vec_t          vecs[7];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            valid_cnt = 0;
    int            ferr_cnt = 0;
    int            first_valid_cyc = 0;
    int            last_rise = 0;
    logic [DW-1:0] last_dout = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor sampled 1 time unit after each active edge.
    always @(posedge clk) begin
        #1;
        if (dout_valid === 1'b1) begin
            if (valid_cnt == 0) first_valid_cyc = cyc;
            valid_cnt = valid_cnt + 1;
            last_dout = dout;
        end
`ifdef SPI_RX_FRAME_ERR_EN
        if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        sclk = 1'b0;
        cs   = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (10) @(negedge clk);
        sclk = 1'b0;
        cs   = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Returns right after the last sclk rise so callers can time the tail.
    task automatic clock_bits(input logic [15:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (10) @(negedge clk);
            sclk = 1'b0;
            mosi = d[i];
            repeat (10) @(negedge clk);
            sclk      = 1'b1;
            last_rise = cyc;
        end
    endtask

    task automatic send_frame(input logic [15:0] d, input int n);
        cs_low();
        clock_bits(d, n);
        cs_high();
    endtask

    initial begin
        rst        = 1'b0;
        cs         = 1'b1;
        sclk       = 1'b0;
        mosi       = 1'b0;
        dout_ready = 1'b1;

        vecs[0] = '{data: 16'h0AAA, nedges: 12, exp_dout: 12'hAAA, exp_valids: 1, exp_ferr: 0, chk_lat: 1'b1};
        vecs[1] = '{data: 16'h33C3, nedges: 14, exp_dout: 12'h3C3, exp_valids: 1, exp_ferr: 0, chk_lat: 1'b0};
        vecs[2] = '{data: 16'h001F, nedges: 5,  exp_dout: 12'h3C3, exp_valids: 0, exp_ferr: 1, chk_lat: 1'b0};
        vecs[3] = '{data: 16'h0F0F, nedges: 12, exp_dout: 12'hF0F, exp_valids: 1, exp_ferr: 0, chk_lat: 1'b1};
        vecs[4] = '{data: 16'h0000, nedges: 12, exp_dout: 12'h000, exp_valids: 1, exp_ferr: 0, chk_lat: 1'b1};
        vecs[5] = '{data: 16'h0FFF, nedges: 12, exp_dout: 12'hFFF, exp_valids: 1, exp_ferr: 0, chk_lat: 1'b1};
        vecs[6] = '{data: 16'h05A5, nedges: 12, exp_dout: 12'h5A5, exp_valids: 1, exp_ferr: 0, chk_lat: 1'b1};

        repeat (5) @(negedge clk);
        check("reset_dout", 32'(dout), 32'h0);
        check("reset_valid", 32'(dout_valid), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            valid_cnt = 0;
            ferr_cnt  = 0;
            send_frame(vecs[i].data, vecs[i].nedges);
            check($sformatf("vec%0d_valid_cycles", i), 32'(valid_cnt), 32'(vecs[i].exp_valids));
            if (vecs[i].exp_valids > 0)
                check($sformatf("vec%0d_dout", i), 32'(last_dout), 32'(vecs[i].exp_dout));
            else
                check($sformatf("vec%0d_dout_held", i), 32'(dout), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'h0);
            if (vecs[i].chk_lat)
                check($sformatf("vec%0d_latency", i), 32'(first_valid_cyc - last_rise), 32'(SYNC + 2));
`ifdef SPI_RX_FRAME_ERR_EN
            check($sformatf("vec%0d_frame_err", i), 32'(ferr_cnt), 32'(vecs[i].exp_ferr));
`endif
        end

        // New frame lands in the same clk as the handshake.
        dout_ready = 1'b0;
        send_frame(16'h00F0, 12);
        check("hs_old_valid", 32'(dout_valid), 32'h1);
        check("hs_old_dout", 32'(dout), 32'h0F0);
        cs_low();
        clock_bits(16'h0777, 12);
        repeat (3) @(negedge clk);
        dout_ready = 1'b1;
        @(negedge clk);
        check("hs_new_dout", 32'(dout), 32'h777);
        check("hs_new_valid", 32'(dout_valid), 32'h1);
        check("hs_no_overrun", 32'(overrun), 32'h0);
        @(negedge clk);
        check("hs_valid_clear", 32'(dout_valid), 32'h0);
        cs_high();

        // Overrun: second frame dropped while first is unaccepted.
        dout_ready = 1'b0;
        send_frame(16'h0123, 12);
        check("ovr_first_dout", 32'(dout), 32'h123);
        check("ovr_first_valid", 32'(dout_valid), 32'h1);
        check("ovr_first_flag", 32'(overrun), 32'h0);
        send_frame(16'h0456, 12);
        check("ovr_kept_dout", 32'(dout), 32'h123);
        check("ovr_kept_valid", 32'(dout_valid), 32'h1);
        check("ovr_flag_set", 32'(overrun), 32'h1);
        dout_ready = 1'b1;
        @(negedge clk);
        check("ovr_valid_clear", 32'(dout_valid), 32'h0);
        check("ovr_sticky", 32'(overrun), 32'h1);

        // Reset mid-frame, released with cs still low.
        valid_cnt = 0;
        ferr_cnt  = 0;
        cs_low();
        clock_bits(16'h0155, 6);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstmid_dout", 32'(dout), 32'h0);
        check("rstmid_valid", 32'(dout_valid), 32'h0);
        check("rstmid_overrun", 32'(overrun), 32'h0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        valid_cnt = 0;
        clock_bits(16'h0015, 6);
        cs_high();
        check("rstmid_tail_no_valid", 32'(valid_cnt), 32'h0);
`ifdef SPI_RX_FRAME_ERR_EN
        check("rstmid_no_frame_err", 32'(ferr_cnt), 32'h0);
`endif
        valid_cnt = 0;
        send_frame(16'h05A5, 12);
        check("rstmid_next_dout", 32'(last_dout), 32'h5A5);
        check("rstmid_next_valid_cycles", 32'(valid_cnt), 32'h1);
        check("rstmid_next_overrun", 32'(overrun), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter DATA_W, default 12: frame length in bits. This matches the upstream SPI master frame.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for sclk, cs and mosi. Legal range is 2..3.
REQ-003 clk  input  1  system clock, rising-edge active.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 sclk  input  1  SPI serial clock from the master, asynchronous to clk.
REQ-006 cs  input  1  chip select from the master, active-low, asynchronous to clk.
REQ-007 mosi  input  1  serial data from the master, asynchronous to clk.
REQ-008 dout  output  DATA_W  received frame. Stable while dout_valid=1.
REQ-009 dout_valid  output  1  frame available.
REQ-010 dout_ready  input  1  consumer accepts the frame.
REQ-011 overrun  output  1  sticky: a frame completed while the previous frame was still unaccepted.
REQ-012 frame_err  output  1  one-clk pulse: cs deasserted mid-frame. Present only with SPI_RX_FRAME_ERR_EN.

Function
REQ-013 sclk, cs and mosi each pass through a SYNC_STAGES-flop synchronizer before any use.
REQ-014 A sample event is a synchronized sclk 0->1 transition while synchronized cs=0.
- mosi_sync is captured in the same clk as the event.
REQ-015 Bits are received LSB-first.
- Bit i of the frame is the i-th sample after cs falls, i = 0..DATA_W-1.
REQ-016 The FSM has three states: IDLE, SHIFT and HOLD.
- IDLE -> SHIFT on synchronized cs 1->0; the bit counter clears to 0.
- SHIFT increments the bit counter per sample event. The counter is sized $clog2(DATA_W+1).
- When sample DATA_W-1 is captured, the FSM enters HOLD.
- HOLD -> IDLE when synchronized cs returns to 1.
REQ-017 Sample events in HOLD are ignored; the frame is not modified.
REQ-018 On the clk after the sample event that captures bit DATA_W-1, dout is loaded from the shift register and dout_valid=1.
- Latency from sclk pin edge to dout_valid is SYNC_STAGES+2 clk cycles.
REQ-019 dout_valid stays 1 and dout stays frozen until a clk with dout_valid=1 and dout_ready=1. dout_valid clears on the following clk.
REQ-020 If a new frame completes while dout_valid=1 and dout_ready=0:
- dout keeps the old frame;
- the new frame is dropped;
- overrun is set to 1.
REQ-021 If a new frame completes in the same clk as the dout_ready handshake, the new frame is loaded, dout_valid stays 1, and overrun is not set.
REQ-022 overrun clears only on reset.
REQ-023 If cs rises in SHIFT before DATA_W samples, the partial frame is discarded, the FSM enters IDLE, and dout/dout_valid are unchanged.
REQ-024 cs 0->1->0 within one clk is not guaranteed to be seen. The master guarantees cs high for at least SYNC_STAGES+1 clk between frames.

Reset
REQ-025 While rst=0 at a clk edge, the following are cleared:
- FSM to IDLE;
- bit counter and shift register to 0;
- dout to 0, dout_valid to 0, overrun to 0, frame_err to 0;
- synchronizer flops: sclk and mosi to 0, cs to 1.
REQ-026 Reset asserted mid-frame aborts the frame with no frame_err pulse. The frame in flight at release is ignored until cs goes high.

Configuration
REQ-027 With macro SPI_RX_FRAME_ERR_EN defined:
- frame_err exists and pulses 1 for exactly one clk on the REQ-023 abort;
- it asserts the clk after synchronized cs rises.
REQ-028 Without SPI_RX_FRAME_ERR_EN:
- port frame_err is absent;
- aborts are silent;
- all other behaviour is identical.

Structure
REQ-029 Package spi_pkg holds:
- the FSM state typedef (IDLE, SHIFT, HOLD);
- the default frame width constant SPI_DATA_W = 12;
- the SPI_SYNC_STAGES default constant.
REQ-030 Sub-module spi_sync is a parameterized N-flop single-bit synchronizer with a reset value parameter. It is instantiated three times.

Verification
REQ-031 Reset hold, then cs low and 12 sclk periods of 20 clk, mosi=0xAAA LSB-first, dout_ready=1.
- dout=0xAAA;
- dout_valid high for exactly 1 clk, SYNC_STAGES+2 clk after the 12th sclk rise;
- overrun=0.
REQ-032 dout_ready=0, frame 0x123, then frame 0x456.
- dout stays 0x123 and dout_valid stays 1;
- overrun=1 after the second frame;
- on dout_ready=1, valid clears the next clk.
REQ-033 cs high after 5 of 12 bits, then a full frame 0xF0F.
- No valid is raised for the partial frame;
- dout=0xF0F;
- with SPI_RX_FRAME_ERR_EN, frame_err pulses once after the abort.
REQ-034 rst=0 asserted after bit 6 of a frame, released while cs is still low.
- All outputs are 0 after reset;
- the remainder of that frame produces no dout_valid;
- the next full frame 0x5A5 is received correctly.
REQ-035 14 sclk edges are sent in one cs-low window with frame 0x3C3.
- dout=0x3C3;
- the extra 2 edges are ignored;
- exactly one dout_valid.
